image_loader: RTL and testbench

- Upstream feeder for the CNN training top.
- Fetches one image record (28x28 8-bit pixels plus a 1-byte label) from a byte-wide synchronous memory and converts pixels to signed fixed point.
- One-hot encodes the label, then presents the frame and labels as stable parallel arrays.
- Double-buffered: the presented frame stays constant while the next image is fetched. The top drives image_index from its input_index counter and pulses load_start.

---
 rtl/cnn_pkg.sv | 29 ++
 rtl/pixel_to_fixed.sv | 22 ++
 rtl/image_loader.sv | 114 +++++++++++
 tb/tb_image_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, derived sizes and loader FSM state encoding for the CNN
// training datapath.
package cnn_pkg;

  localparam int unsigned WIDTH             = 32;
  localparam int unsigned FIXED_POINT_INDEX = 16;
  localparam int unsigned INPUT_DIM_HEIGHT  = 28;
  localparam int unsigned INPUT_DIM_WIDTH   = 28;
  localparam int unsigned NUM_CLASSES       = 10;
  localparam int unsigned NUM_IMAGES        = 10000;
  localparam int unsigned PIXEL_WIDTH       = 8;

  localparam int unsigned PIXELS       = INPUT_DIM_HEIGHT * INPUT_DIM_WIDTH;
  localparam int unsigned RECORD_BYTES = PIXELS + 1;
  localparam int unsigned PIXEL_SHIFT  = FIXED_POINT_INDEX - PIXEL_WIDTH;
  localparam int unsigned IDX_W        = $clog2(NUM_IMAGES);
  localparam int unsigned ADDR_W       = $clog2(NUM_IMAGES * RECORD_BYTES);
  localparam int unsigned CNT_W        = $clog2(RECORD_BYTES);

  localparam logic [WIDTH-1:0] FIXED_ONE = WIDTH'(1) << FIXED_POINT_INDEX;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } loader_state_t;

endpackage

// File: rtl/pixel_to_fixed.sv
// Combinational raw-byte to signed fixed-point pixel converter.
// Build option: IMAGE_LOADER_NORMALIZE_EN selects the zero-centred mapping.
module pixel_to_fixed
  import cnn_pkg::*;
(
  input  logic [PIXEL_WIDTH-1:0]  pixel,
  output logic signed [WIDTH-1:0] fixed_c
);

  logic [WIDTH-1:0] scaled_c;

  // Byte lands in the top PIXEL_WIDTH fractional bits: 0xFF -> 255/256
  assign scaled_c = WIDTH'(pixel) << PIXEL_SHIFT;

`ifdef IMAGE_LOADER_NORMALIZE_EN
  // Shift the range down by one half so pixels are centred on zero
  assign fixed_c = signed'(scaled_c - (WIDTH'(1) << (FIXED_POINT_INDEX - 1)));
`else
  assign fixed_c = signed'(scaled_c);
`endif

endmodule

// File: rtl/image_loader.sv
// Fetches one image record from byte-wide memory into a shadow buffer, then
// commits it in one edge to stable, double-buffered frame/label outputs.
// Build option: IMAGE_LOADER_NORMALIZE_EN (zero-centred pixel mapping).
module image_loader
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic [IDX_W-1:0]        image_index,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [PIXEL_WIDTH-1:0]  mem_rdata,
  output logic signed [WIDTH-1:0] output_data [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH],
  output logic signed [WIDTH-1:0] output_labels [NUM_CLASSES],
  output logic                    busy,
  output logic                    valid,
  output logic                    done,
  output logic                    err
);

  loader_state_t              state;
  logic [CNT_W-1:0]           counter;
  logic                       rd_q;
  logic [CNT_W-1:0]           cap_idx;
  logic signed [WIDTH-1:0]    shadow [PIXELS];
  logic [PIXEL_WIDTH-1:0]     label_q;
  logic signed [WIDTH-1:0]    pixel_fixed_c;

  pixel_to_fixed u_pixel_to_fixed (
    .pixel   (mem_rdata),
    .fixed_c (pixel_fixed_c)
  );

  // Capture path: data returns one cycle after the read, tagged with its offset
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= 1'b0;
      cap_idx <= '0;
      label_q <= '0;
      for (int i = 0; i < int'(PIXELS); i++) shadow[i] <= '0;
    end else begin
      rd_q    <= mem_rd_en;
      cap_idx <= counter;
      if (rd_q) begin
        if (cap_idx == CNT_W'(RECORD_BYTES - 1)) label_q <= mem_rdata;
        else                                     shadow[cap_idx] <= pixel_fixed_c;
      end
    end
  end

  // Loader FSM with registered memory interface, status and presented outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int r = 0; r < int'(INPUT_DIM_HEIGHT); r++)
        for (int c = 0; c < int'(INPUT_DIM_WIDTH); c++)
          output_data[r][c] <= '0;
      for (int l = 0; l < int'(NUM_CLASSES); l++) output_labels[l] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            if (image_index < IDX_W'(NUM_IMAGES)) begin
              state     <= FETCH;
              counter   <= '0;
              mem_rd_en <= 1'b1;
              mem_addr  <= ADDR_W'(image_index) * ADDR_W'(RECORD_BYTES);
              busy      <= 1'b1;
              err       <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (counter == CNT_W'(RECORD_BYTES - 1)) begin
            mem_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            counter  <= counter + CNT_W'(1);
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          state <= COMMIT;
        end
        COMMIT: begin
          for (int r = 0; r < int'(INPUT_DIM_HEIGHT); r++)
            for (int c = 0; c < int'(INPUT_DIM_WIDTH); c++)
              output_data[r][c] <= shadow[r * int'(INPUT_DIM_WIDTH) + c];
          // An out-of-range label matches no class, leaving all labels zero
          for (int l = 0; l < int'(NUM_CLASSES); l++)
            output_labels[l] <= (label_q == PIXEL_WIDTH'(l)) ? signed'(FIXED_ONE) : '0;
          if (label_q >= PIXEL_WIDTH'(NUM_CLASSES)) err <= 1'b1;
          done  <= 1'b1;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Directed self-checking bench for image_loader.
module tb_image_loader;
  import cnn_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    load_start;
  logic [IDX_W-1:0]        image_index;
  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [PIXEL_WIDTH-1:0]  mem_rdata;
  logic signed [WIDTH-1:0] output_data [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH];
  logic signed [WIDTH-1:0] output_labels [NUM_CLASSES];
  logic                    busy, valid, done, err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int c0 = 0;
  int rd_count, first_addr, first_cyc, last_addr, last_cyc, done_cnt;
  bit busy_seen;

`ifdef IMAGE_LOADER_NORMALIZE_EN
  localparam logic [31:0] NORM_OFS = 32'h0000_8000;
`else
  localparam logic [31:0] NORM_OFS = 32'h0000_0000;
`endif

  image_loader dut (
    .clk           (clk),
    .reset         (reset),
    .load_start    (load_start),
    .image_index   (image_index),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .output_data   (output_data),
    .output_labels (output_labels),
    .busy          (busy),
    .valid         (valid),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Record memory: pixel = addr mod 256; labels 7 for record 3, 12 for record 5
  function automatic logic [7:0] mem_byte(input int unsigned a);
    int unsigned rec, off;
    rec = a / 785;
    off = a % 785;
    if (off < 784) return 8'(a % 256);
    if (rec == 3) return 8'd7;
    if (rec == 5) return 8'd12;
    return 8'(rec % 10);
  endfunction

  always @(posedge clk) mem_rdata <= mem_rd_en ? mem_byte(32'(mem_addr)) : 8'h00;

  function automatic logic [31:0] exp_pix(input int unsigned b);
    return (32'(b) << 8) - NORM_OFS;
  endfunction

  function automatic int count_nonzero();
    int n = 0;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        if (output_data[r][c] !== 32'sd0) n++;
    for (int l = 0; l < 10; l++)
      if (output_labels[l] !== 32'sd0) n++;
    return n;
  endfunction

  function automatic int label_mismatches(input int hot);
    int n = 0;
    for (int l = 0; l < 10; l++)
      if (output_labels[l] !== ((l == hot) ? 32'sh0001_0000 : 32'sd0)) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    if (mem_rd_en === 1'b1) begin
      if (rd_count == 0) begin
        first_addr = int'(mem_addr);
        first_cyc  = cyc - c0;
      end
      last_addr = int'(mem_addr);
      last_cyc  = cyc - c0;
      rd_count++;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic clear_stats();
    rd_count = 0; first_addr = -1; first_cyc = -1;
    last_addr = -1; last_cyc = -1; done_cnt = 0; busy_seen = 1'b0;
  endtask

  task automatic start_load(input int idx);
    @(posedge clk); #1;
    load_start  = 1'b1;
    image_index = IDX_W'(idx);
    c0 = cyc;
    clear_stats();
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start = 1'b0; image_index = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    clear_stats();
    repeat (10) @(negedge clk);
    n_cmp++; if (count_nonzero() !== 0) begin n_bad++;
      $display("FAIL reset_outputs: nonzero=%0d want 0", count_nonzero()); end
    n_cmp++; if ({valid, done, busy, err, mem_rd_en} !== 5'b0) begin n_bad++;
      $display("FAIL reset_flags: {v,d,b,e,rd}=%b want 00000", {valid, done, busy, err, mem_rd_en}); end
    n_cmp++; if (rd_count !== 0) begin n_bad++;
      $display("FAIL reset_no_reads: reads=%0d want 0", rd_count); end
    n_cmp++; if (mem_addr !== '0) begin n_bad++;
      $display("FAIL reset_addr: got %0d want 0", mem_addr); end
  endtask

  task automatic test_load_record3();
    bit got;
    start_load(3);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL r3_busy: got %b want 1", busy); end
    wait_done(got);
    n_cmp++; if (!got || (cyc - c0) != 788) begin n_bad++;
      $display("FAIL r3_done_cycle: got %0d (seen %0b) want 788", cyc - c0, got); end
    repeat (3) @(negedge clk);
    n_cmp++; if (first_addr != 2355 || first_cyc != 1) begin n_bad++;
      $display("FAIL r3_first_read: addr %0d cyc %0d want 2355 cyc 1", first_addr, first_cyc); end
    n_cmp++; if (last_addr != 3139 || last_cyc != 785 || rd_count != 785) begin n_bad++;
      $display("FAIL r3_last_read: addr %0d cyc %0d n %0d want 3139 785 785", last_addr, last_cyc, rd_count); end
    n_cmp++; if (done_cnt != 1) begin n_bad++;
      $display("FAIL r3_done_pulse: got %0d pulses want 1", done_cnt); end
    n_cmp++; if (output_data[0][0] !== exp_pix(8'h33)) begin n_bad++;
      $display("FAIL r3_pix00: got %h want %h", output_data[0][0], exp_pix(8'h33)); end
    n_cmp++; if (output_data[27][27] !== exp_pix(8'h42)) begin n_bad++;
      $display("FAIL r3_pix2727: got %h want %h", output_data[27][27], exp_pix(8'h42)); end
    n_cmp++; if (label_mismatches(7) != 0) begin n_bad++;
      $display("FAIL r3_labels: %0d wrong, lbl7=%h want 00010000", label_mismatches(7), output_labels[7]); end
    n_cmp++; if ({valid, busy, err} !== 3'b100) begin n_bad++;
      $display("FAIL r3_flags: {v,b,e}=%b want 100", {valid, busy, err}); end
  endtask

  task automatic test_ignore_mid_fetch();
    bit got;
    int held_bad = 0;
    start_load(1);
    repeat (99) @(posedge clk);
    #1 load_start = 1'b1; image_index = IDX_W'(2);
    @(posedge clk); #1 load_start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; break; end
      if (output_data[0][0] !== exp_pix(8'h33)) held_bad++;
    end
    n_cmp++; if ((cyc - c0) != 788) begin n_bad++;
      $display("FAIL mid_done_cycle: got %0d want 788", cyc - c0); end
    n_cmp++; if (held_bad != 0) begin n_bad++;
      $display("FAIL mid_frame_held: %0d cycles changed want 0", held_bad); end
    n_cmp++; if (output_data[0][0] !== exp_pix(8'h11) || label_mismatches(1) != 0) begin n_bad++;
      $display("FAIL mid_commit_r1: pix %h want %h, label errs %0d", output_data[0][0], exp_pix(8'h11), label_mismatches(1)); end
    repeat (2) @(negedge clk);
    n_cmp++; if (rd_count != 785 || first_addr != 785) begin n_bad++;
      $display("FAIL mid_reads: n %0d first %0d want 785 785", rd_count, first_addr); end
  endtask

  task automatic test_bad_index();
    start_load(10000);
    repeat (5) @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++;
      $display("FAIL badidx_err: got %b want 1", err); end
    n_cmp++; if (busy_seen || rd_count != 0 || done_cnt != 0) begin n_bad++;
      $display("FAIL badidx_quiet: busy %b reads %0d done %0d want 0 0 0", busy_seen, rd_count, done_cnt); end
  endtask

  task automatic test_bad_label();
    bit got;
    start_load(5);
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++;
      $display("FAIL badlbl_err_clear: got %b want 0", err); end
    wait_done(got);
    n_cmp++; if (!got || (cyc - c0) != 788) begin n_bad++;
      $display("FAIL badlbl_done: cyc %0d seen %0b want 788", cyc - c0, got); end
    n_cmp++; if (err !== 1'b1 || label_mismatches(-1) != 0) begin n_bad++;
      $display("FAIL badlbl_labels: err %b nonzero labels %0d want 1 0", err, label_mismatches(-1)); end
    n_cmp++; if (output_data[0][0] !== exp_pix(8'h55) || valid !== 1'b1) begin n_bad++;
      $display("FAIL badlbl_frame: pix %h valid %b want %h 1", output_data[0][0], valid, exp_pix(8'h55)); end
  endtask

  task automatic test_back_to_back();
    bit got;
    int held_bad = 0;
    int d1;
    start_load(0);
    wait_done(got);
    n_cmp++; if (!got || err !== 1'b0 || output_data[0][1] !== exp_pix(1)) begin n_bad++;
      $display("FAIL b2b_first: seen %0b err %b pix01 %h want 1 0 %h", got, err, output_data[0][1], exp_pix(1)); end
    d1 = cyc;
    c0 = cyc;
    clear_stats();
    load_start = 1'b1; image_index = IDX_W'(1);
    @(posedge clk); #1 load_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; break; end
      if (output_data[0][1] !== exp_pix(1) || output_labels[0] !== 32'sh0001_0000) held_bad++;
    end
    n_cmp++; if (!got || (cyc - d1) != 788) begin n_bad++;
      $display("FAIL b2b_second_done: gap %0d seen %0b want 788", cyc - d1, got); end
    n_cmp++; if (held_bad != 0) begin n_bad++;
      $display("FAIL b2b_hold: %0d unstable cycles want 0", held_bad); end
    n_cmp++; if (output_data[0][0] !== exp_pix(8'h11) || label_mismatches(1) != 0) begin n_bad++;
      $display("FAIL b2b_commit_r1: pix %h want %h label errs %0d", output_data[0][0], exp_pix(8'h11), label_mismatches(1)); end
  endtask

  task automatic test_reset_mid_fetch();
    start_load(3);
    repeat (399) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    clear_stats();
    @(negedge clk);
    n_cmp++; if ({busy, valid, mem_rd_en, err} !== 4'b0 || count_nonzero() != 0) begin n_bad++;
      $display("FAIL rstmid_state: {b,v,rd,e}=%b nonzero %0d want 0000 0", {busy, valid, mem_rd_en, err}, count_nonzero()); end
    repeat (900) @(negedge clk);
    n_cmp++; if (done_cnt != 0 || rd_count != 0) begin n_bad++;
      $display("FAIL rstmid_no_done: done %0d reads %0d want 0 0", done_cnt, rd_count); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_load_record3();
    test_ignore_mid_fetch();
    test_bad_index();
    test_bad_label();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
